// File: rtl/tl_monitor.sv
// Traffic-light sequence monitor: locks onto RED->YELLOW->GREEN->RED and flags order,
// encoding and dwell-time violations. Optional sticky error status under TL_MON_STICKY_EN.
module tl_monitor #(
    parameter int RED_CYC = 8,
    parameter int YEL_CYC = 4,
    parameter int GRN_CYC = 16,
    parameter int CNT_W   = 5,
    parameter int CYC_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       light,
`ifdef TL_MON_STICKY_EN
    input  logic             clr_err,
    output logic [2:0]       err_status,
`endif
    output logic             locked,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_code,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_BAD = 2'b11;

    typedef enum logic {UNSYNC, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [1:0]         light_q, light_d;
    logic               first_q, first_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               seq_q, seq_d;
    logic               dw_q, dw_d;
    logic               code_q, code_d;
    logic [CNT_W-1:0]   exp_len;
    logic               legal;

    always_comb begin
        case (light_q)
            C_RED:   exp_len = CNT_W'(RED_CYC);
            C_YEL:   exp_len = CNT_W'(YEL_CYC);
            C_GRN:   exp_len = CNT_W'(GRN_CYC);
            default: exp_len = '0;
        endcase
        legal = (light_q == C_RED && light == C_YEL) ||
                (light_q == C_YEL && light == C_GRN) ||
                (light_q == C_GRN && light == C_RED);
    end

    always_comb begin
        state_d = state_q;
        light_d = light_q;
        first_d = first_q;
        ovr_d   = ovr_q;
        dwell_d = dwell_q;
        cyc_d   = cyc_q;
        seq_d   = 1'b0;
        dw_d    = 1'b0;
        code_d  = 1'b0;
        if (light == C_BAD) begin
            // The sample following an illegal code has no trustworthy predecessor.
            code_d  = 1'b1;
            state_d = UNSYNC;
            ovr_d   = 1'b0;
            light_d = C_BAD;
            first_d = 1'b1;
        end else if (first_q) begin
            light_d = light;
            first_d = 1'b0;
        end else if (light != light_q) begin
            light_d = light;
            if (state_q == UNSYNC) begin
                if (legal) begin
                    state_d = LOCKED;
                    dwell_d = CNT_W'(1);
                    ovr_d   = 1'b0;
                end else begin
                    seq_d = 1'b1;
                end
            end else if (legal) begin
                if (!ovr_q && dwell_q != exp_len)
                    dw_d = 1'b1;
                dwell_d = CNT_W'(1);
                ovr_d   = 1'b0;
                if (light_q == C_GRN)
                    cyc_d = cyc_q + CYC_W'(1);
            end else begin
                seq_d   = 1'b1;
                state_d = UNSYNC;
                ovr_d   = 1'b0;
            end
        end else if (state_q == LOCKED) begin
            if (dwell_q != '1)
                dwell_d = dwell_q + CNT_W'(1);
            // Overstay is reported once, on the first sample past the required dwell.
            if (dwell_q == exp_len && !ovr_q) begin
                dw_d  = 1'b1;
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNSYNC;
            light_q <= C_RED;
            first_q <= 1'b1;
            ovr_q   <= 1'b0;
            dwell_q <= '0;
            cyc_q   <= '0;
            seq_q   <= 1'b0;
            dw_q    <= 1'b0;
            code_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            light_q <= light_d;
            first_q <= first_d;
            ovr_q   <= ovr_d;
            dwell_q <= dwell_d;
            cyc_q   <= cyc_d;
            seq_q   <= seq_d;
            dw_q    <= dw_d;
            code_q  <= code_d;
        end
    end

`ifdef TL_MON_STICKY_EN
    logic [2:0] stat_q, stat_d;

    // A new pulse wins over a simultaneous clear.
    always_comb begin
        stat_d = clr_err ? {code_d, dw_d, seq_d} : (stat_q | {code_d, dw_d, seq_d});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stat_q <= 3'b000;
        else          stat_q <= stat_d;
    end

    assign err_status = stat_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_seq   = seq_q;
    assign err_dwell = dw_q;
    assign err_code  = code_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_tl_monitor.sv
// Bench for tl_monitor: directed table, corner-case sequences and randomized traffic
// checked against a run-length model of the light sequence.
module tb_tl_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] light = 2'b00;
    logic       locked, err_seq, err_dwell, err_code;
    logic [7:0] cycle_cnt;
`ifdef TL_MON_STICKY_EN
    logic       clr_err = 1'b0;
    logic [2:0] err_status;
`endif

    int errs = 0;
    int checks = 0;

    tl_monitor dut (
        .clk(clk), .reset_n(reset_n), .light(light),
`ifdef TL_MON_STICKY_EN
        .clr_err(clr_err), .err_status(err_status),
`endif
        .locked(locked), .err_seq(err_seq), .err_dwell(err_dwell),
        .err_code(err_code), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Model: previous phase (-1 = none trusted), sync flag, length of current run.
    int m_prev, m_run, m_cyc;
    bit m_sync, m_flag;
    bit e_es, e_ed, e_ec;
    logic [2:0] m_stat;

    function automatic int exp_of(input int p);
        return (p == 0) ? 8 : (p == 1) ? 4 : 16;
    endfunction

    task automatic model_reset();
        m_prev = -1; m_run = 0; m_cyc = 0; m_sync = 0; m_flag = 0;
        e_es = 0; e_ed = 0; e_ec = 0; m_stat = 3'b000;
    endtask

    task automatic model_step(input int cur, input bit clr);
        e_es = 0; e_ed = 0; e_ec = 0;
        if (cur == 3) begin
            e_ec = 1; m_sync = 0; m_flag = 0; m_prev = -1;
        end else if (m_prev < 0) begin
            m_prev = cur;
        end else if (cur == m_prev) begin
            if (m_sync) begin
                m_run++;
                if (m_run == exp_of(m_prev) + 1 && !m_flag) begin
                    e_ed = 1; m_flag = 1;
                end
            end
        end else begin
            if ((m_prev + 1) % 3 == cur) begin
                if (m_sync) begin
                    if (!m_flag && m_run != exp_of(m_prev)) e_ed = 1;
                    if (m_prev == 2) m_cyc = (m_cyc + 1) % 256;
                end
                m_sync = 1; m_run = 1; m_flag = 0;
            end else begin
                e_es = 1; m_sync = 0; m_flag = 0;
            end
            m_prev = cur;
        end
        m_stat = clr ? {e_ec, e_ed, e_es} : (m_stat | {e_ec, e_ed, e_es});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] l);
        bit c;
        c = 0;
        light = l;
`ifdef TL_MON_STICKY_EN
        c = clr_err;
`endif
        @(posedge clk);
        #1;
        model_step(int'(l), c);
        chk("locked", locked, m_sync);
        chk("err_seq", err_seq, e_es);
        chk("err_dwell", err_dwell, e_ed);
        chk("err_code", err_code, e_ec);
        chk("cycle_cnt", cycle_cnt, m_cyc);
`ifdef TL_MON_STICKY_EN
        chk("err_status", err_status, m_stat);
`endif
    endtask

    task automatic drive(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_locked", locked, 0);
        chk("rst_err", {err_seq, err_dwell, err_code}, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
`ifdef TL_MON_STICKY_EN
        chk("rst_err_status", err_status, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] l;
        logic       lk, es, ed, ec;
        logic [7:0] cyc;
    } vec_t;

    vec_t tbl [13];
    int   nerr, idx, p, len;

    initial begin
        tbl[0]  = '{2'b00, 0, 0, 0, 0, 8'd0};
        tbl[1]  = '{2'b00, 0, 0, 0, 0, 8'd0};
        tbl[2]  = '{2'b01, 1, 0, 0, 0, 8'd0};
        tbl[3]  = '{2'b11, 0, 0, 0, 1, 8'd0};
        tbl[4]  = '{2'b11, 0, 0, 0, 1, 8'd0};
        tbl[5]  = '{2'b10, 0, 0, 0, 0, 8'd0};
        tbl[6]  = '{2'b00, 1, 0, 0, 0, 8'd0};
        tbl[7]  = '{2'b10, 0, 1, 0, 0, 8'd0};
        tbl[8]  = '{2'b01, 0, 1, 0, 0, 8'd0};
        tbl[9]  = '{2'b10, 1, 0, 0, 0, 8'd0};
        tbl[10] = '{2'b00, 1, 0, 1, 0, 8'd1};
        tbl[11] = '{2'b01, 1, 0, 1, 0, 8'd1};
        tbl[12] = '{2'b11, 0, 0, 0, 1, 8'd1};

        model_reset();
        #2;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].l);
            chk($sformatf("tbl%0d", i), {locked, err_seq, err_dwell, err_code, cycle_cnt},
                {tbl[i].lk, tbl[i].es, tbl[i].ed, tbl[i].ec, tbl[i].cyc});
        end

        // Ideal sequence x3 from reset
        do_reset();
        nerr = 0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) begin step(2'b00); nerr += int'(err_seq | err_dwell | err_code); end
            for (int i = 0; i < 4; i++) begin step(2'b01); nerr += int'(err_seq | err_dwell | err_code); end
            for (int i = 0; i < 16; i++) begin step(2'b10); nerr += int'(err_seq | err_dwell | err_code); end
        end
        step(2'b00);
        nerr += int'(err_seq | err_dwell | err_code);
        chk("ideal_no_err", nerr, 0);
        chk("ideal_cycles", cycle_cnt, 3);
        chk("ideal_locked", locked, 1);

        // RED short by two
        drive(2'b00, 5);
        step(2'b01);
        chk("short_red", {err_dwell, locked}, 2'b11);

        // GREEN overstay
        drive(2'b01, 3);
        nerr = 0; idx = 0;
        for (int i = 1; i <= 20; i++) begin
            step(2'b10);
            if (err_dwell) begin nerr++; idx = i; end
        end
        step(2'b00);
        if (err_dwell) nerr++;
        chk("ovr_pulses", nerr, 1);
        chk("ovr_index", idx, 17);
        chk("ovr_cycles", cycle_cnt, 4);

        // RED->GREEN skip, then relock on G->R
        drive(2'b00, 7);
        step(2'b10);
        chk("skip_seq", {err_seq, locked}, 2'b10);
        step(2'b00);
        chk("skip_relock", {locked, cycle_cnt}, {1'b1, 8'd4});

        // Illegal code mid-YELLOW
        drive(2'b00, 7);
        drive(2'b01, 2);
        nerr = 0;
        for (int i = 0; i < 3; i++) begin
            step(2'b11);
            if (err_code && !locked) nerr++;
        end
        chk("code_cycles", nerr, 3);
        step(2'b01);
        chk("code_after", {locked, err_seq, err_code}, 3'b000);
        step(2'b10);
        chk("code_relock", locked, 1);

        // Reset mid-GREEN with five cycles counted
        drive(2'b10, 15);
        step(2'b00);
        chk("pre_rst_cycles", cycle_cnt, 5);
        drive(2'b00, 7);
        drive(2'b01, 4);
        drive(2'b10, 5);
        do_reset();

`ifdef TL_MON_STICKY_EN
        step(2'b00);
        step(2'b10);
        drive(2'b10, 3);
        chk("sticky_hold", err_status, 3'b001);
        clr_err = 1'b1;
        step(2'b11);
        chk("sticky_setclr", err_status, 3'b100);
        step(2'b10);
        clr_err = 1'b0;
        chk("sticky_clr", err_status, 3'b000);
`endif

        // Randomized traffic
        do_reset();
        p = 0;
        for (int ph = 0; ph < 150; ph++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) drive(2'b11, int'($urandom_range(1, 3)));
            else if (r == 1) p = (p + 1) % 3;
            if ($urandom_range(0, 9) < 6) len = exp_of(p);
            else len = int'($urandom_range(1, exp_of(p) + 5));
            for (int i = 0; i < len; i++) begin
`ifdef TL_MON_STICKY_EN
                clr_err = ($urandom_range(0, 7) == 0);
`endif
                step(2'(p));
            end
            p = (p + 1) % 3;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
